// File: rtl/key_event_arbiter.sv
// key_event_arbiter: captures per-key press/release pulses as pending events,
// grants them round-robin into a single registered valid/ready slot, flags
// dropped events, and generates the periodic scan tick for the scan stage.
module key_event_arbiter #(
    parameter int unsigned N_KEY    = 5,
    parameter int unsigned SCAN_DIV = 2000000,
    parameter int unsigned CNT_W    = 21
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_KEY-1:0] push_pulse,
    input  logic [N_KEY-1:0] release_pulse,
    output logic             scan_tick,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [2:0]       evt_key,
    output logic             evt_type,
    output logic [N_KEY-1:0] pending,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       RR_INIT  = 3'(N_KEY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [N_KEY-1:0] press_q, press_d;
    logic [N_KEY-1:0] rel_q, rel_d;
    logic [N_KEY-1:0] ord_q, ord_d;     // 1: press is the older pending event
    logic [2:0]       rr_q, rr_d;
    logic             valid_q, valid_d;
    logic [2:0]       key_q, key_d;
    logic             type_q, type_d;
    logic             ovf_q, ovf_d;

    logic [N_KEY-1:0] req;
    logic [N_KEY-1:0] sel;
    logic [N_KEY-1:0] gnt_p;
    logic [N_KEY-1:0] gnt_r;
    logic [2:0]       idx;
    logic [2:0]       win_idx;
    logic             win_found;
    logic             win_type;
    logic             load;
    logic             grant;
    logic             drop;
    logic             rem_p;
    logic             rem_r;

    // Scan counter wraps at SCAN_DIV-1; tick fires the cycle after the wrap value.
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Round-robin search starting after the last granted key.
    always_comb begin
        req       = press_q | rel_q;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_KEY; k++) begin
            idx = 3'((32'(rr_q) + k) % N_KEY);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        win_type = (press_q[win_idx] && rel_q[win_idx]) ? ord_q[win_idx] : press_q[win_idx];
        load     = !valid_q || evt_ready;
        grant    = load && win_found;
        sel      = '0;
        if (grant) begin
            sel[win_idx] = 1'b1;
        end
        gnt_p = win_type ? sel : '0;
        gnt_r = win_type ? '0 : sel;
    end

    // Pending capture, ordering and drop detection; a bit granted this cycle
    // is treated as free so a same-type pulse on that edge is retained.
    always_comb begin
        press_d = press_q;
        rel_d   = rel_q;
        ord_d   = ord_q;
        drop    = 1'b0;
        rem_p   = 1'b0;
        rem_r   = 1'b0;
        for (int unsigned i = 0; i < N_KEY; i++) begin
            rem_p      = press_q[i] & ~gnt_p[i];
            rem_r      = rel_q[i] & ~gnt_r[i];
            press_d[i] = rem_p | push_pulse[i];
            rel_d[i]   = rem_r | release_pulse[i];
            drop       = drop | (rem_p & push_pulse[i]) | (rem_r & release_pulse[i]);
            if (!rem_p && !rem_r) begin
                if (push_pulse[i] || release_pulse[i]) begin
                    ord_d[i] = push_pulse[i];
                end
            end else if (gnt_p[i] || gnt_r[i]) begin
                // Both were pending; the survivor is now the older one.
                ord_d[i] = ~win_type;
            end
        end
    end

    // Output slot load, round-robin pointer and sticky overflow.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = win_found;
            if (win_found) begin
                key_d  = win_idx;
                type_d = win_type;
                rr_d   = win_idx;
            end
        end
        ovf_d = drop | (ovf_q & ~ovf_clr);
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            press_q <= '0;
            rel_q   <= '0;
            ord_q   <= '0;
            rr_q    <= RR_INIT;
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            ord_q   <= ord_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
        end
    end

    assign scan_tick = tick_q;
    assign evt_valid = valid_q;
    assign evt_key   = key_q;
    assign evt_type  = type_q;
    assign pending   = press_q | rel_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Testbench for key_event_arbiter: per-key event queues model the pending
// state, with round-robin selection and a scan counter kept as plain integers.
module tb_key_event_arbiter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [4:0] push_pulse = '0;
    logic [4:0] release_pulse = '0;
    logic       scan_tick;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_key;
    logic       evt_type;
    logic [4:0] pending;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit         mq [0:4][$];
    logic       m_valid;
    logic [2:0] m_key;
    logic       m_type;
    logic       m_ovf;
    int         m_rr;
    int         m_n;
    logic [3:0] emitted[$];

    key_event_arbiter #(.N_KEY(5), .SCAN_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .clr(clr), .push_pulse(push_pulse), .release_pulse(release_pulse),
        .scan_tick(scan_tick), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_key(evt_key), .evt_type(evt_type), .pending(pending),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mq[i].delete();
        m_valid = 0; m_key = 0; m_type = 0; m_ovf = 0; m_rr = 4; m_n = 0;
    endtask

    function automatic bit has(input int k, input bit t);
        bit r = 0;
        for (int j = 0; j < mq[k].size(); j++) if (mq[k][j] == t) r = 1;
        return r;
    endfunction

    function automatic logic [4:0] m_pend();
        logic [4:0] r = '0;
        for (int i = 0; i < 5; i++) r[i] = (mq[i].size() > 0);
        return r;
    endfunction

    function automatic logic m_tick();
        return (m_n > 0) && (m_n % DIV == 0);
    endfunction

    task automatic model_edge(input logic [4:0] p, input logic [4:0] r, input logic rdy, input logic oc);
        bit found = 0;
        bit set = 0;
        int w = 0;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= 5; k++) begin
                if (!found && mq[(m_rr + k) % 5].size() > 0) begin
                    found = 1;
                    w = (m_rr + k) % 5;
                end
            end
            if (found) begin
                m_key = 3'(w); m_type = mq[w].pop_front(); m_rr = w; m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (p[i]) begin if (has(i, 1)) set = 1; else mq[i].push_back(1); end
            if (r[i]) begin if (has(i, 0)) set = 1; else mq[i].push_back(0); end
        end
        m_ovf = set | (m_ovf & !oc);
        m_n++;
    endtask

    task automatic cycle(input logic [4:0] p, input logic [4:0] r, input logic rdy, input logic oc);
        push_pulse = p; release_pulse = r; evt_ready = rdy; ovf_clr = oc;
        if (evt_valid && rdy) emitted.push_back({evt_key, evt_type});
        @(posedge clk);
        model_edge(p, r, rdy, oc);
        #1;
        push_pulse = '0; release_pulse = '0; ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        model_reset();
        #2;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", evt_valid); else passed++;
        checks++; if (evt_key !== 3'd0) $display("FAIL reset_key got %0d want 0", evt_key); else passed++;
        checks++; if (evt_type !== 1'b0) $display("FAIL reset_type got %0b want 0", evt_type); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", overflow); else passed++;
        checks++; if (pending !== 5'd0) $display("FAIL reset_pending got %b want 00000", pending); else passed++;
        checks++; if (scan_tick !== 1'b0) $display("FAIL reset_tick got %0b want 0", scan_tick); else passed++;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_scan_tick();
        for (int c = 1; c <= 13; c++) begin
            cycle('0, '0, 1'b1, 1'b0);
            checks++;
            if (scan_tick !== m_tick())
                $display("FAIL scan_tick edge%0d got %0b want %0b", c, scan_tick, m_tick());
            else passed++;
        end
    endtask

    task automatic test_single_press();
        cycle(5'b00100, '0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (evt_valid !== m_valid || pending !== m_pend() || (m_valid && (evt_key !== m_key || evt_type !== m_type)))
                $display("FAIL single_press c%0d got v%0b k%0d t%0b p%b want v%0b k%0d t%0b p%b",
                         c, evt_valid, evt_key, evt_type, pending, m_valid, m_key, m_type, m_pend());
            else passed++;
            cycle('0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0011, 4'b1001, 4'b0001, 4'b0011};
        do_reset();
        emitted.delete();
        cycle(5'b10011, '0, 1'b1, 1'b0);
        repeat (4) cycle('0, '0, 1'b1, 1'b0);
        cycle(5'b00011, '0, 1'b1, 1'b0);
        repeat (3) cycle('0, '0, 1'b1, 1'b0);
        checks++;
        if (emitted.size() != 5) $display("FAIL simul_count got %0d want 5", emitted.size());
        else passed++;
        for (int i = 0; i < 5; i++) begin
            if (i < emitted.size()) begin
                checks++;
                if (emitted[i] !== exp_seq[i])
                    $display("FAIL simul_order[%0d] got key%0d type%0b want key%0d type%0b",
                             i, emitted[i][3:1], emitted[i][0], exp_seq[i][3:1], exp_seq[i][0]);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_seq [2];
        exp_seq = '{4'b0111, 4'b0110};
        do_reset();
        emitted.delete();
        cycle(5'b01000, '0, 1'b0, 1'b0);
        cycle('0, 5'b01000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle('0, '0, 1'b0, 1'b0);
            checks++;
            if (evt_valid !== 1'b1 || evt_key !== 3'd3 || evt_type !== 1'b1 || overflow !== 1'b0)
                $display("FAIL stall_hold c%0d got v%0b k%0d t%0b o%0b want v1 k3 t1 o0",
                         c, evt_valid, evt_key, evt_type, overflow);
            else passed++;
        end
        repeat (3) cycle('0, '0, 1'b1, 1'b0);
        checks++;
        if (emitted.size() != 2) $display("FAIL bp_count got %0d want 2", emitted.size());
        else passed++;
        for (int i = 0; i < 2; i++) begin
            if (i < emitted.size()) begin
                checks++;
                if (emitted[i] !== exp_seq[i])
                    $display("FAIL bp_order[%0d] got key%0d type%0b want key%0d type%0b",
                             i, emitted[i][3:1], emitted[i][0], exp_seq[i][3:1], exp_seq[i][0]);
                else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        int k1 = 0;
        do_reset();
        emitted.delete();
        cycle(5'b00001, '0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle(5'b00010, '0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_first got %0b want 0", overflow); else passed++;
        cycle(5'b00010, '0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else passed++;
        cycle('0, '0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %0b want 0", overflow); else passed++;
        cycle(5'b00010, '0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %0b want 1", overflow); else passed++;
        repeat (4) cycle('0, '0, 1'b1, 1'b0);
        foreach (emitted[i]) if (emitted[i] == 4'b0011) k1++;
        checks++; if (k1 != 1) $display("FAIL ovf_key1_once got %0d want 1", k1); else passed++;
        checks++; if (emitted.size() != 2) $display("FAIL ovf_total got %0d want 2", emitted.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(5'b00001, '0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle(5'b01110, '0, 1'b0, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || pending !== 5'b01110)
            $display("FAIL mid_pre got v%0b p%b want v1 p01110", evt_valid, pending);
        else passed++;
        @(negedge clk);
        clr = 1'b1;
        model_reset();
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_key !== 3'd0 || evt_type !== 1'b0 || pending !== 5'd0 ||
            overflow !== 1'b0 || scan_tick !== 1'b0)
            $display("FAIL mid_reset got v%0b k%0d t%0b p%b o%0b s%0b want all 0",
                     evt_valid, evt_key, evt_type, pending, overflow, scan_tick);
        else passed++;
        #2;
        clr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle('0, '0, 1'b1, 1'b0);
            checks++;
            if (evt_valid !== 1'b0 || pending !== 5'd0 || scan_tick !== m_tick())
                $display("FAIL post_reset c%0d got v%0b p%b s%0b want v0 p00000 s%0b",
                         c, evt_valid, pending, scan_tick, m_tick());
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [4:0] p, r;
        logic       rdy, oc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            p   = ($urandom_range(0, 2) == 0) ? 5'($urandom()) : 5'd0;
            r   = ($urandom_range(0, 2) == 0) ? 5'($urandom()) : 5'd0;
            rdy = ($urandom_range(0, 3) != 0);
            oc  = ($urandom_range(0, 15) == 0);
            cycle(p, r, rdy, oc);
            checks++;
            if (evt_valid !== m_valid) $display("FAIL rnd_valid c%0d got %0b want %0b", c, evt_valid, m_valid);
            else passed++;
            if (m_valid) begin
                checks++;
                if (evt_key !== m_key || evt_type !== m_type)
                    $display("FAIL rnd_event c%0d got k%0d t%0b want k%0d t%0b", c, evt_key, evt_type, m_key, m_type);
                else passed++;
            end
            checks++;
            if (pending !== m_pend()) $display("FAIL rnd_pending c%0d got %b want %b", c, pending, m_pend());
            else passed++;
            checks++;
            if (overflow !== m_ovf) $display("FAIL rnd_ovf c%0d got %0b want %0b", c, overflow, m_ovf);
            else passed++;
            checks++;
            if (scan_tick !== m_tick()) $display("FAIL rnd_tick c%0d got %0b want %0b", c, scan_tick, m_tick());
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_tick();
        test_single_press();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
